// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style fetch front end.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  // Branch displacement is a signed word offset; scale to bytes.
  function automatic logic [WORD_W-1:0] branch_offset(input logic [15:0] imm);
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection: jump, taken branch, or fall-through.
module npc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              J,
  input  logic              B,
  input  logic              Zero,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] pc4;
  logic [WORD_W-1:0] jump_target;
  logic [WORD_W-1:0] branch_target;
  logic              unused_opcode;

  assign pc4           = pc + 32'd4;
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc4 + branch_offset(instr[15:0]);
  assign unused_opcode = ^instr[31:26];

  // Jump wins over branch when the decoder raises both.
  always_comb begin
    next_pc = pc4;
    if (J) begin
      next_pc = jump_target;
    end else if (B && Zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for the decoder,
// then advances pc once the downstream stage releases it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              J,
  input  logic              B,
  input  logic              Zero,
  input  logic              stall,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] retired
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] retired_q, retired_d;
  logic [WORD_W-1:0] next_pc;
  logic              unused_npc_lsb;

  npc u_npc (
    .pc      (pc_q),
    .instr   (instr_q),
    .J       (J),
    .B       (B),
    .Zero    (Zero),
    .next_pc (next_pc)
  );

  assign unused_npc_lsb = ^next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= {RESET_PC[WORD_W-1:2], 2'b00};
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Decoder flags and stall only matter while an instruction is on display.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_d      = {next_pc[WORD_W-1:2], 2'b00};
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule
